morse_letter_sequencer: RTL and testbench

Queues 3-bit letter codes and plays them back-to-back through the existing Morse letter transmitter, one letter at a time. It drives the transmitter's `Start`/`Letter` inputs, counts its `NewBitOut` pulses to detect end of letter, and inserts a fixed inter-letter silence. It is the only block allowed to drive the transmitter's `Start`, `Letter` and `Reset` inputs.

---
 rtl/morse_letter_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_morse_letter_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_letter_sequencer.sv
// Letter queue and playback sequencer for the Morse letter transmitter.
// Pops one queued letter at a time, watches NewBitIn for end of letter, then holds a silent gap.
module morse_letter_sequencer #(
   parameter int CLOCK_FREQUENCY = 100,
   parameter int FIFO_DEPTH      = 4,
   parameter int GAP_SYMBOLS     = 2
) (
   input  logic                          ClockIn,
   input  logic                          Resetn,
   input  logic [2:0]                    LetterIn,
   input  logic                          LetterValid,
   output logic                          LetterReady,
   input  logic                          Abort,
   input  logic                          NewBitIn,
   output logic                          Start,
   output logic [2:0]                    Letter,
   output logic                          Clear,
   output logic                          Busy,
   output logic [$clog2(FIFO_DEPTH):0]   Count,
   output logic                          LetterDone,
   output logic                          Error
);

   // state | meaning
   // IDLE  | waiting for a queued letter
   // LOAD  | one cycle: Start high, head popped, counters loaded
   // SEND  | counting transmitter bit pulses, timeout running
   // GAP   | inter-letter silence, LetterDone on the last cycle
   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SEND,
      S_GAP
   } state_t;

   localparam int SYM      = (CLOCK_FREQUENCY >> 2) + 1;
   localparam int TO_LOAD  = 13 * SYM - 1;
   localparam int GAP_LOAD = GAP_SYMBOLS * SYM - 1;
   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int CW       = AW + 1;
   localparam int TW       = $clog2(TO_LOAD + 2);
   localparam int GW       = $clog2(GAP_LOAD + 2);

   localparam logic [TW-1:0] TO_INIT  = TW'(TO_LOAD);
   localparam logic [GW-1:0] GAP_INIT = GW'(GAP_LOAD);
   localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);

   state_t          state, state_nxt;
   logic [3:0]      bit_cnt, bit_nxt;
   logic [TW-1:0]   to_cnt, to_nxt;
   logic [GW-1:0]   gap_cnt, gap_nxt;
   logic            err_q, err_nxt;
   logic [2:0]      letter_q, letter_nxt;
   logic            start_q, clear_q, done_q;
   logic            push, pop;

   logic [2:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count_q;

   // Readiness uses start-of-cycle occupancy, so a same-cycle pop never frees a slot.
   assign LetterReady = (count_q != FULL) && !Abort;
   assign push        = LetterValid && LetterReady;

   always_comb begin
      state_nxt  = state;
      bit_nxt    = bit_cnt;
      to_nxt     = to_cnt;
      gap_nxt    = gap_cnt;
      err_nxt    = err_q;
      letter_nxt = letter_q;
      pop        = 1'b0;
      case (state)
         S_IDLE: begin
            if (count_q != '0) begin
               state_nxt  = S_LOAD;
               letter_nxt = mem[rd_ptr];
            end
         end
         S_LOAD: begin
            pop       = 1'b1;
            bit_nxt   = '0;
            to_nxt    = TO_INIT;
            state_nxt = S_SEND;
         end
         S_SEND: begin
            // A 12th pulse on the timeout's last cycle still counts as success.
            if (NewBitIn && (bit_cnt == 4'd11)) begin
               bit_nxt   = bit_cnt + 4'd1;
               gap_nxt   = GAP_INIT;
               state_nxt = S_GAP;
            end else begin
               if (NewBitIn) begin
                  bit_nxt = bit_cnt + 4'd1;
               end
               if (to_cnt == '0) begin
                  err_nxt   = 1'b1;
                  gap_nxt   = GAP_INIT;
                  state_nxt = S_GAP;
               end else begin
                  to_nxt = to_cnt - TW'(1);
               end
            end
         end
         S_GAP: begin
            if (gap_cnt == '0) begin
               state_nxt = S_IDLE;
            end else begin
               gap_nxt = gap_cnt - GW'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (Abort) begin
         state_nxt  = S_IDLE;
         bit_nxt    = '0;
         to_nxt     = '0;
         gap_nxt    = '0;
         err_nxt    = 1'b0;
         letter_nxt = letter_q;
         pop        = 1'b0;
      end
   end

   always_ff @(posedge ClockIn or negedge Resetn) begin
      if (!Resetn) begin
         state    <= S_IDLE;
         bit_cnt  <= '0;
         to_cnt   <= '0;
         gap_cnt  <= '0;
         err_q    <= 1'b0;
         letter_q <= '0;
         start_q  <= 1'b0;
         clear_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state    <= state_nxt;
         bit_cnt  <= bit_nxt;
         to_cnt   <= to_nxt;
         gap_cnt  <= gap_nxt;
         err_q    <= err_nxt;
         letter_q <= letter_nxt;
         start_q  <= (state_nxt == S_LOAD);
         clear_q  <= Abort;
         done_q   <= (state_nxt == S_GAP) && (gap_nxt == '0);
      end
   end

   always_ff @(posedge ClockIn or negedge Resetn) begin
      if (!Resetn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (Abort) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge ClockIn) begin
      if (push) begin
         mem[wr_ptr] <= LetterIn;
      end
   end

   assign Start      = start_q;
   assign Letter     = letter_q;
   assign Clear      = clear_q;
   assign Busy       = (state != S_IDLE);
   assign Count      = count_q;
   assign LetterDone = done_q;
   assign Error      = err_q;

endmodule

// File: tb/tb_morse_letter_sequencer.sv
// Scoreboard bench for morse_letter_sequencer with a behavioural transmitter model.
// Expected letters are queued at push acceptance and checked by a negedge monitor.
module tb_morse_letter_sequencer;

   localparam int SYM = 26;
   localparam int GAP = 52;
   localparam int D   = 4;

   logic       ClockIn = 1'b0;
   logic       Resetn;
   logic [2:0] LetterIn;
   logic       LetterValid;
   logic       LetterReady;
   logic       Abort;
   logic       NewBitIn;
   logic       Start;
   logic [2:0] Letter;
   logic       Clear;
   logic       Busy;
   logic [2:0] Count;
   logic       LetterDone;
   logic       Error;

   morse_letter_sequencer #(
      .CLOCK_FREQUENCY(100),
      .FIFO_DEPTH(D),
      .GAP_SYMBOLS(2)
   ) dut (
      .ClockIn(ClockIn),
      .Resetn(Resetn),
      .LetterIn(LetterIn),
      .LetterValid(LetterValid),
      .LetterReady(LetterReady),
      .Abort(Abort),
      .NewBitIn(NewBitIn),
      .Start(Start),
      .Letter(Letter),
      .Clear(Clear),
      .Busy(Busy),
      .Count(Count),
      .LetterDone(LetterDone),
      .Error(Error)
   );

   always #5 ClockIn = ~ClockIn;

   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   logic [2:0] exp_q[$];
   bit         m_busy = 0, m_err = 0, pend_start = 0, prev_abort = 0, in_reset = 1;
   int         done_cyc = -1, err_cyc = -1;
   int         tx_mode = 0;
   bit         tx_active = 0;
   int         tx_wait = 0, tx_pulses = 0;

   always @(posedge ClockIn) cyc++;

   function automatic void chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endfunction

   // Transmitter model: tx_mode 0 nominal (random phase, noise when idle), 1 silent, 2 late 12th pulse.
   initial begin
      NewBitIn = 1'b0;
      forever begin
         @(posedge ClockIn);
         #1;
         if (tx_active) begin
            tx_wait--;
            if (tx_wait == 0) begin
               NewBitIn = 1'b1;
               tx_pulses++;
               tx_wait = SYM;
               if (tx_pulses == 12) begin
                  tx_active = 0;
                  done_cyc = cyc + GAP;
               end
            end else begin
               NewBitIn = 1'b0;
            end
         end else begin
            NewBitIn = (tx_mode == 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
         end
      end
   end

   // Monitor: compares every observable output against the model each cycle.
   initial begin
      forever begin
         @(negedge ClockIn);
         if (!in_reset) begin
            bit es, ed;
            es = pend_start;
            if (cyc == err_cyc) begin
               m_err = 1;
               err_cyc = -1;
            end
            chk("count", int'(Count), exp_q.size());
            chk("ready", int'(LetterReady), int'((exp_q.size() != D) && !Abort));
            chk("start", int'(Start), int'(es));
            chk("clear", int'(Clear), int'(prev_abort));
            chk("error", int'(Error), int'(m_err));
            if (es) begin
               m_busy = 1;
               if (exp_q.size() > 0) begin
                  chk("letter", int'(Letter), int'(exp_q[0]));
                  void'(exp_q.pop_front());
               end
               tx_pulses = 0;
               case (tx_mode)
                  0: begin tx_wait = $urandom_range(1, SYM); tx_active = 1; end
                  2: begin tx_wait = 2 * SYM; tx_active = 1; end
                  default: begin
                     tx_active = 0;
                     err_cyc = cyc + 13 * SYM + 1;
                     done_cyc = cyc + 13 * SYM + GAP;
                  end
               endcase
            end
            chk("busy", int'(Busy), int'(m_busy));
            ed = (cyc == done_cyc);
            chk("done", int'(LetterDone), int'(ed));
            pend_start = !m_busy && (exp_q.size() != 0) && !Abort;
            if (ed) begin
               m_busy = 0;
               done_cyc = -1;
            end
            prev_abort = Abort;
         end
      end
   end

   task automatic step();
      @(posedge ClockIn);
      #2;
   endtask

   task automatic push(input logic [2:0] l);
      bit acc;
      int n;
      acc = 0;
      n = 0;
      LetterIn = l;
      LetterValid = 1'b1;
      while (!acc && n < 4000) begin
         acc = (exp_q.size() != D) && !Abort;
         @(posedge ClockIn);
         if (acc) exp_q.push_back(l);
         #2;
         n++;
      end
      if (!acc) chk("push_timeout", 0, 1);
      LetterValid = 1'b0;
   endtask

   task automatic do_abort();
      Abort = 1'b1;
      @(posedge ClockIn);
      exp_q.delete();
      m_busy = 0;
      m_err = 0;
      err_cyc = -1;
      done_cyc = -1;
      tx_active = 0;
      #2;
      Abort = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((m_busy || exp_q.size() != 0 || pend_start) && n < 6000) begin
         step();
         n++;
      end
      if (n >= 6000) chk("idle_timeout", 0, 1);
      repeat (3) step();
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_busy = 0;
      m_err = 0;
      pend_start = 0;
      prev_abort = 0;
      done_cyc = -1;
      err_cyc = -1;
      tx_active = 0;
   endtask

   task automatic check_reset();
      chk("rst_start", int'(Start), 0);
      chk("rst_letter", int'(Letter), 0);
      chk("rst_clear", int'(Clear), 0);
      chk("rst_busy", int'(Busy), 0);
      chk("rst_count", int'(Count), 0);
      chk("rst_done", int'(LetterDone), 0);
      chk("rst_error", int'(Error), 0);
      chk("rst_ready", int'(LetterReady), 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      Resetn = 1'b0;
      LetterIn = '0;
      LetterValid = 1'b0;
      Abort = 1'b0;
      #3;
      check_reset();
      @(posedge ClockIn);
      @(posedge ClockIn);
      #3;
      Resetn = 1'b1;
      in_reset = 0;
      step();

      // Single letter E with nominal transmitter.
      push(3'b100);
      wait_idle();

      // Six back-to-back pushes: queue fills, the last waits for a LOAD to free a slot.
      for (int i = 0; i < 6; i++) push(3'(i + 1));
      wait_idle();

      // Abort mid-SEND with two letters still queued.
      push(3'd5);
      push(3'd6);
      push(3'd7);
      n = 0;
      while (tx_pulses < 3 && n < 2000) begin step(); n++; end
      if (n >= 2000) chk("abort_wait", 0, 1);
      do_abort();
      repeat (60) step();
      wait_idle();

      // Silent transmitter: timeout, sticky Error, then Abort clears it.
      tx_mode = 1;
      push(3'd3);
      wait_idle();
      repeat (20) step();
      do_abort();
      repeat (3) step();

      // 12th pulse lands on the timeout's final cycle: no Error.
      tx_mode = 2;
      push(3'd2);
      wait_idle();
      tx_mode = 0;

      // Random traffic with occasional mid-SEND aborts.
      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(0, 40)) step();
         push(3'($urandom_range(0, 7)));
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 100)) step();
            if (tx_active) do_abort();
         end
      end
      wait_idle();

      // Asynchronous reset in the middle of a GAP with letters queued.
      push(3'd1);
      push(3'd2);
      push(3'd6);
      n = 0;
      while (done_cyc == -1 && n < 2000) begin step(); n++; end
      if (n >= 2000) chk("gap_wait", 0, 1);
      repeat (20) step();
      #1;
      Resetn = 1'b0;
      in_reset = 1;
      model_reset();
      #1;
      check_reset();
      @(posedge ClockIn);
      @(posedge ClockIn);
      #3;
      Resetn = 1'b1;
      in_reset = 0;
      step();
      push(3'd7);
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
